// File: rtl/primary_descrambler_3_if.sv
// rtl/primary_descrambler_3_if.sv - host register bus and data stream bundle for primary_descrambler_3
interface primary_descrambler_3_if #(
  parameter int NUM_OF_STEPS = 13
) ();
  logic                    write;
  logic [11:0]             addr;
  logic [31:0]             lfsrdin;
  logic                    din_valid;
  logic                    sof;
  logic [NUM_OF_STEPS-1:0] din;
  logic                    dout_valid;
  logic [NUM_OF_STEPS-1:0] dout;
  logic [1:0]              state;
  logic                    err;

  modport master (
    output write, addr, lfsrdin, din_valid, sof, din,
    input  dout_valid, dout, state, err
  );

  modport slave (
    input  write, addr, lfsrdin, din_valid, sof, din,
    output dout_valid, dout, state, err
  );
endinterface

// File: rtl/primary_descrambler_3.sv
// rtl/primary_descrambler_3.sv - 347-bit LFSR descrambler, 13 bits/word, seed reload on sof; optional PRIMARY_DESCR_BYPASS_EN
module primary_descrambler_3 #(
  parameter int POLY_WIDTH   = 347,
  parameter int NUM_OF_STEPS = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  primary_descrambler_3_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int MSB = POLY_WIDTH - 1;

  state_t                  state_q, state_d;
  logic [POLY_WIDTH-1:0]   seed_q, lfsr_q, base, advanced;
  logic [NUM_OF_STEPS-1:0] ks, dout_q;
  logic                    dout_valid_q, err_q, arm_q, arm_d;
  logic [15:0]             frame_len_q, wcnt_q, wcnt_d;
  logic                    accept, reseed, ctrl_wr, err_set, err_clr;
`ifdef PRIMARY_DESCR_BYPASS_EN
  logic                    bypass_q;
`endif

  // one LFSR step: MSB feeds back into bit 0 and the five tap positions
  function automatic logic [POLY_WIDTH-1:0] lfsr_step(input logic [POLY_WIDTH-1:0] s);
    logic [POLY_WIDTH-1:0] n;
    n      = {s[MSB-1:0], s[MSB]};
    n[31]  = s[30]  ^ s[MSB];
    n[64]  = s[63]  ^ s[MSB];
    n[162] = s[161] ^ s[MSB];
    n[209] = s[208] ^ s[MSB];
    n[236] = s[235] ^ s[MSB];
    return n;
  endfunction

  // decode word acceptance, frame restart and host control writes
  always_comb begin
    accept  = 1'b0;
    reseed  = 1'b0;
    ctrl_wr = bus.write && (bus.addr == 12'h0AC);
    arm_d   = ctrl_wr ? bus.lfsrdin[0] : arm_q;
    if (bus.din_valid) begin
      if (state_q == ARMED && bus.sof) accept = 1'b1;
      if (state_q == RUN)              accept = 1'b1;
    end
    reseed  = accept && bus.sof;
    err_set = accept && bus.sof && (state_q == RUN);
    err_clr = ctrl_wr && bus.lfsrdin[2];
    wcnt_d  = reseed ? 16'd1 : wcnt_q + 16'd1;
  end

  // keystream from the pre-word state and the state 13 steps later
  always_comb begin
    base     = reseed ? seed_q : lfsr_q;
    advanced = base;
    for (int i = 0; i < NUM_OF_STEPS; i++) advanced = lfsr_step(advanced);
    ks = '0;
    for (int k = 0; k < NUM_OF_STEPS; k++) ks[k] = base[MSB-k];
`ifdef PRIMARY_DESCR_BYPASS_EN
    if (bypass_q) ks = '0;
`endif
  end

  // next state; a disarm write overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm_d) state_d = ARMED;
      ARMED:   if (accept) state_d = RUN;
      RUN:     if (accept && !bus.sof && frame_len_q != 16'd0 && wcnt_d == frame_len_q)
                 state_d = ARMED;
      default: state_d = IDLE;
    endcase
    if (!arm_d) state_d = IDLE;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // host-writable seed shadow, control and frame length
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed_q      <= '0;
      arm_q       <= 1'b0;
      frame_len_q <= '0;
`ifdef PRIMARY_DESCR_BYPASS_EN
      bypass_q    <= 1'b0;
`endif
    end else if (bus.write) begin
      for (int n = 0; n < 10; n++)
        if (bus.addr == 12'(12'h0A1 + n)) seed_q[32*n +: 32] <= bus.lfsrdin;
      if (bus.addr == 12'h0AB) seed_q[MSB:320] <= bus.lfsrdin[MSB-320:0];
      if (bus.addr == 12'h0AD) frame_len_q <= bus.lfsrdin[15:0];
      if (ctrl_wr) begin
        arm_q    <= bus.lfsrdin[0];
`ifdef PRIMARY_DESCR_BYPASS_EN
        bypass_q <= bus.lfsrdin[1];
`endif
      end
    end
  end

  // working LFSR, word counter and registered output word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q       <= '0;
      wcnt_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= accept;
      if (accept) begin
        lfsr_q <= advanced;
        wcnt_q <= wcnt_d;
        dout_q <= bus.din ^ ks;
      end
    end
  end

  // sticky framing error; a new error wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.state      = state_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_primary_descrambler_3.sv
// tb/tb_primary_descrambler_3.sv - scoreboard bench for primary_descrambler_3 with a keystream reference model
module tb_primary_descrambler_3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  primary_descrambler_3_if #(.NUM_OF_STEPS(13)) bus ();

  primary_descrambler_3 #(.POLY_WIDTH(347), .NUM_OF_STEPS(13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [12:0] exp_q[$];
  logic [1:0]  exp_state = 2'd0;
  logic        exp_err   = 1'b0;
  logic [12:0] exp_dout  = '0;

  logic [346:0] m_seed, m_lfsr;
  logic [15:0]  m_wcnt, m_flen;
  logic         m_arm, m_byp, m_err;
  logic [1:0]   m_state;

  int taps[5] = '{30, 63, 161, 208, 235};

  // reference LFSR: shift up, top bit wraps to bit 0 and is xored in after every tap
  function automatic logic [346:0] ref_step(input logic [346:0] s);
    logic [346:0] n;
    logic fb;
    fb = s[346];
    n  = s << 1;
    n[0] = fb;
    foreach (taps[i]) n[taps[i]+1] = s[taps[i]] ^ fb;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // monitor: pops expected words whenever the DUT presents an output
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", 32'(bus.state), 32'(exp_state));
      check("err", 32'(bus.err), 32'(exp_err));
      if (bus.dout_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_dout: got %h expected no output at %0t", bus.dout, $time);
        end else begin
          logic [12:0] e;
          e = exp_q.pop_front();
          check("dout", 32'(bus.dout), 32'(e));
          exp_dout = e;
        end
      end else begin
        check("dout_hold", 32'(bus.dout), 32'(exp_dout));
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL missing_dout: got no output expected %h at %0t", exp_q[0], $time);
          exp_q.delete();
        end
      end
    end
  end

  task automatic model_reset();
    m_seed = '0; m_lfsr = '0; m_wcnt = '0; m_flen = '0;
    m_arm = 0; m_byp = 0; m_err = 0; m_state = 2'd0;
  endtask

  // one clock cycle: drive inputs, advance the model, commit expectations after the edge
  task automatic cyc(input logic w, input logic [11:0] a, input logic [31:0] ld,
                     input logic dv, input logic sf, input logic [12:0] d, input logic rn);
    logic acc, rs, cw, arm_n, pv, set_e;
    logic [12:0] pval, ks;
    logic [346:0] s;
    logic [15:0] nw;
    logic [1:0] ns;
    bus.write = w; bus.addr = a; bus.lfsrdin = ld;
    bus.din_valid = dv; bus.sof = sf; bus.din = d; rst_n = rn;
    pv = 0; pval = '0;
    if (!rn) begin
      model_reset();
    end else begin
      acc   = dv && ((m_state == 2'd1 && sf) || m_state == 2'd2);
      rs    = acc && sf;
      cw    = w && a == 12'h0AC;
      arm_n = cw ? ld[0] : m_arm;
      ns    = m_state;
      set_e = acc && sf && m_state == 2'd2;
      if (acc) begin
        s = rs ? m_seed : m_lfsr;
        for (int k = 0; k < 13; k++) begin
          ks[k] = s[346];
          s = ref_step(s);
        end
`ifdef PRIMARY_DESCR_BYPASS_EN
        if (m_byp) ks = '0;
`endif
        pv = 1; pval = d ^ ks;
        m_lfsr = s;
        nw = rs ? 16'd1 : m_wcnt + 16'd1;
        if (m_state == 2'd1) ns = 2'd2;
        else if (!sf && m_flen != 0 && nw == m_flen) ns = 2'd1;
        m_wcnt = nw;
      end
      if (m_state == 2'd0 && arm_n) ns = 2'd1;
      if (!arm_n) ns = 2'd0;
      m_state = ns;
      if (set_e) m_err = 1;
      else if (cw && ld[2]) m_err = 0;
      if (w) begin
        if (a >= 12'h0A1 && a <= 12'h0AA) m_seed[32*(a-12'h0A1) +: 32] = ld;
        if (a == 12'h0AB) m_seed[346:320] = ld[26:0];
        if (a == 12'h0AD) m_flen = ld[15:0];
        if (cw) begin m_arm = ld[0]; m_byp = ld[1]; end
      end
    end
    @(posedge clk);
    #1;
    if (!rn) begin
      exp_q.delete();
      exp_dout = '0;
    end else if (pv) exp_q.push_back(pval);
    exp_state = m_state;
    exp_err   = m_err;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cyc(1, a, d, 0, 0, '0, 1);
  endtask

  task automatic word(input logic sf, input logic [12:0] d);
    cyc(0, 12'h000, '0, 1, sf, d, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 12'h000, '0, 0, 0, '0, 1);
  endtask

  initial begin
    model_reset();
    cyc(0, 12'h000, '0, 0, 0, '0, 0);
    cyc(0, 12'h000, '0, 1, 1, 13'h1FFF, 0);
    chk_en = 1;
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);

    // first-word keystream: only seed bit 346 set
    wr(12'h0AB, 32'h0400_0000);
    wr(12'h0AD, 32'd4);
    wr(12'h0AC, 32'h1);
    word(1, 13'h0000);
    check("first_word", 32'(bus.dout), 32'h0001);
    check("first_state", 32'(bus.state), 32'd2);
    word(0, 13'h0000);
    check("second_word", 32'(bus.dout), 32'h0000);
    word(0, 13'h0A5A);
    word(0, 13'h1234);
    check("frame_end_state", 32'(bus.state), 32'd1);

    // frame length 2 then reseed
    wr(12'h0AD, 32'd2);
    word(1, 13'h0000);
    word(0, 13'h0000);
    check("len2_state", 32'(bus.state), 32'd1);
    word(1, 13'h0000);
    check("reseed_word", 32'(bus.dout), 32'h0001);

    // gaps inside a frame
    wr(12'h0A3, 32'hDEAD_BEEF);
    wr(12'h0AD, 32'd6);
    word(0, 13'h0F0F);
    idle(5);
    word(0, 13'h1111);
    idle(3);
    word(0, 13'h0202);

    // early sof is a framing error
    wr(12'h0A3, 32'h0);
    wr(12'h0AD, 32'd8);
    word(1, 13'h0000);
    word(0, 13'h0000);
    word(1, 13'h0000);
    check("early_sof_err", 32'(bus.err), 32'd1);
    check("early_sof_dout", 32'(bus.dout), 32'h0001);
    check("early_sof_state", 32'(bus.state), 32'd2);
    wr(12'h0AC, 32'h5);
    check("err_clear", 32'(bus.err), 32'd0);

    // drop in ARMED, disarm with a word in flight, reset mid-frame
    wr(12'h0AC, 32'h0);
    check("disarm_idle", 32'(bus.state), 32'd0);
    wr(12'h0AC, 32'h1);
    word(0, 13'h0123);
    check("drop_valid", 32'(bus.dout_valid), 32'd0);
    word(1, 13'h0456);
    word(0, 13'h0789);
    cyc(1, 12'h0AC, 32'h0, 1, 0, 13'h0ABC, 1);
    check("disarm_word_valid", 32'(bus.dout_valid), 32'd1);
    check("disarm_state", 32'(bus.state), 32'd0);
    wr(12'h0AC, 32'h1);
    word(1, 13'h1357);
    cyc(0, 12'h000, '0, 1, 0, 13'h0246, 0);
    check("midrst_valid", 32'(bus.dout_valid), 32'd0);
    check("midrst_dout", 32'(bus.dout), 32'd0);
    check("midrst_state", 32'(bus.state), 32'd0);

`ifdef PRIMARY_DESCR_BYPASS_EN
    wr(12'h0AB, 32'h0400_0000);
    wr(12'h0AC, 32'h3);
    word(1, 13'h1ABC);
    check("bypass_dout", 32'(bus.dout), 32'h1ABC);
    cyc(1, 12'h0AC, 32'h1, 1, 0, 13'h0000, 1);
    word(0, 13'h0000);
    word(0, 13'h1FFF);
`endif

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [11:0] a;
      logic [31:0] d;
      r = int'($urandom_range(0, 999));
      if (r < 4) begin
        cyc(0, 12'h000, '0, $urandom_range(0, 1), $urandom_range(0, 1), 13'($urandom), 0);
      end else if (r < 110) begin
        int sel;
        sel = int'($urandom_range(0, 3));
        if (sel == 0) begin
          a = 12'(12'h0A1 + $urandom_range(0, 10));
          d = $urandom;
        end else if (sel == 1) begin
          int lens[5] = '{0, 2, 3, 5, 8};
          a = 12'h0AD;
          d = 32'(lens[$urandom_range(0, 4)]);
        end else begin
          a = 12'h0AC;
          d = {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) != 0)};
        end
        cyc(1, a, d, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, 13'($urandom), 1);
      end else begin
        cyc(0, 12'h000, '0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) < 3, 13'($urandom), 1);
      end
    end

    idle(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/primary_descrambler_3.md
# primary_descrambler_3

Receive-side counterpart of the primary scrambler LFSR. It regenerates the same 347-bit keystream, 13 bits per accepted word, and XORs it onto incoming scrambled data. A host-programmed seed is reloaded at every frame start (`sof`). A small state machine tracks arming, frame length and framing errors.

## Interface
- `POLY_WIDTH`, 347, LFSR length.
- `NUM_OF_STEPS`, 13, LFSR steps per accepted word; also the data width.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `write` in 1: host register write strobe.
- `addr` in 12: host register address.
- `lfsrdin` in 32: host write data.
- `din_valid` in 1: `din` carries a scrambled word this cycle.
- `sof` in 1: qualifies `din_valid`; marks the first word of a frame.
- `din` in `NUM_OF_STEPS`: scrambled data.
- `dout_valid` out 1: `dout` carries a descrambled word.
- `dout` out `NUM_OF_STEPS`: descrambled data.
- `state` out 2: 0 = IDLE, 1 = ARMED, 2 = RUN.
- `err` out 1: sticky framing error.

## Operation
- **Registers** (write-only, take effect on the clock edge with `write`=1):
  - 0x0A1..0x0AB: seed words 0..10. Word n maps to seed[32n+31:32n]; word 10 maps to seed[346:320] from `lfsrdin[26:0]`.
  - 0x0AC: control. bit0 arm; bit1 bypass; bit2 write-1-to-clear `err`.
  - 0x0AD: `frame_len[15:0]`. 0 = unbounded.
- **Seed shadow vs. working register**: seed registers are separate from the working LFSR `lfsr`. A seed write during RUN affects only the next reseed.
- **LFSR step** (identical to the transmitter):
  - new[0] = old[346].
  - new[t+1] = old[t] ^ old[346] for t ∈ {30, 63, 161, 208, 235}.
  - Every other bit: new[t+1] = old[t].
- **Keystream per word**: ks[k] = S[346-k], k = 0..12, where S is the state before the word. `dout[k]` = `din[k]` ^ ks[k]. The LFSR then advances 13 steps.
- **FSM**:
  - IDLE: `lfsr` holds; inputs are ignored. Arm=1 → ARMED.
  - ARMED: waits for `din_valid`&`sof`. On that word, S = seed; the word is descrambled; `lfsr` ← seed advanced 13 steps; `wcnt` ← 1; → RUN. A word with `din_valid` and no `sof` is dropped (no `dout_valid`).
  - RUN: each `din_valid` word uses S = `lfsr`, then `lfsr` advances and `wcnt` increments. Cycles without `din_valid` hold `lfsr` and `wcnt`.
    - When the accepted word makes `wcnt` == `frame_len` (`frame_len`≠0): → ARMED.
    - `sof` arriving in RUN before `frame_len` words is a framing error. `err` ← 1; the word is treated as a new frame start (reseed, `wcnt` ← 1, stay in RUN).
- **Disarm**: writing arm=0 in any state → IDLE next cycle. A word accepted in that same cycle is still processed.
- **`wcnt`**: 16-bit, wraps modulo 2^16 when `frame_len`=0.
- **`err` set vs. clear**: set has priority over the write-1-to-clear in the same cycle.

## Timing
- `dout` and `dout_valid` are registered; latency is 1 cycle from the accepted `din` to `dout`.
- `dout_valid`=1 exactly one cycle after each accepted word (ARMED+`sof`, or RUN). No back-pressure.
- `dout` holds its last value when `dout_valid`=0.
- Register writes and data acceptance in the same cycle: the data word uses pre-write register values.
- **Reset values**: `dout`=0, `dout_valid`=0, `err`=0, `state`=IDLE, `lfsr`=0, seed=0, control=0, `frame_len`=0, `wcnt`=0.
- **Reset mid-frame**: everything returns to reset values on the next edge; no output is produced for words in the reset cycle.

## Configuration
- `PRIMARY_DESCR_BYPASS_EN` defined:
  - Control bit1=1 → `dout` = `din` (keystream forced to 0).
  - The LFSR, `wcnt` and the FSM still advance normally, so clearing bypass mid-frame resumes with the correct keystream.
- Macro undefined: bit1 is ignored; descrambling is always active.

## Test plan
- **First-word keystream**: seed word10 = 0x0400_0000 (only bit 346), others 0; `frame_len`=4; arm; send `sof`+`din`=13'h0000, then 13'h0000. Expected: `dout`=13'h0001 then 13'h0000, each one cycle after input; `state`=2.
- **Frame end and reseed**: same seed, `frame_len`=2. Send 2 words → `state` returns to 1. Next `sof`+13'h0000 → `dout`=13'h0001 again.
- **Gap handling**: in RUN, deassert `din_valid` for 5 cycles mid-frame. Expected: no `dout_valid`; output after the gap equals the gap-free run.
- **Early `sof`**: `frame_len`=8; `sof` on word 3. Expected: `err`=1, word 3 `dout`=13'h0001, `state`=2. Write 0x0AC=0x5 → `err`=0.
- **Drop, disarm and reset**: a non-`sof` word in ARMED → no `dout_valid`. Write arm=0 during RUN → `state`=0 next cycle. `rst_n`=0 mid-frame → all outputs 0 and IDLE next edge.
- **Bypass** (macro defined): set bit1, send `din`=13'h1ABC → `dout`=13'h1ABC. Clear bypass on the next word → keystream continues in phase with the non-bypass reference.
